// File: rtl/cmos_pkg.sv
// Shared types and constants for the synthetic DVP pattern source.
// The LFSR constants are only consumed when CMOS_PATGEN_LFSR_EN is defined.
package cmos_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } patgen_state_t;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_LFSR  = 2'd3;

    localparam logic [7:0] LFSR_SEED    = 8'h01;
    // Taps for x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] LFSR_OFF_VAL = 8'h80;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/cmos_patgen_lfsr8.sv
// 8-bit Fibonacci LFSR for the noise pattern; only built with CMOS_PATGEN_LFSR_EN.
// load_i reseeds and has priority over en_i.
`ifdef CMOS_PATGEN_LFSR_EN
module cmos_patgen_lfsr8
    import cmos_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       load_i,
    output logic [7:0] state_o
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = LFSR_SEED;
        end else if (en_i) begin
            state_d = lfsr8_next(state_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule
`endif

// File: rtl/cmos_dvp_pattern_gen.sv
// Synthetic DVP sensor source with MT9V034-style frame timing and four test patterns.
// Define CMOS_PATGEN_LFSR_EN to build the LFSR noise pattern (mode 3); otherwise mode 3 is flat 8'h80.
module cmos_dvp_pattern_gen
    import cmos_pkg::*;
#(
    parameter int H_ACTIVE     = 752,
    parameter int H_BLANK      = 94,
    parameter int VSYNC_LINES  = 2,
    parameter int VBACK_LINES  = 4,
    parameter int V_ACTIVE     = 480,
    parameter int VFRONT_LINES = 4
) (
    input  logic          cmos_pclk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [1:0]    pattern_sel,
    output logic          cmos_vsync,
    output logic          cmos_href,
    output logic [7:0]    cmos_data,
    output logic          frame_start,
    output logic          frame_done,
    output logic [15:0]   frame_cnt,
    output patgen_state_t dbg_state
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int V_MAX_A = (VSYNC_LINES > VBACK_LINES) ? VSYNC_LINES : VBACK_LINES;
    localparam int V_MAX_B = (V_ACTIVE > VFRONT_LINES) ? V_ACTIVE : VFRONT_LINES;
    localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
    localparam int LW      = ($clog2(V_MAX) > 10) ? $clog2(V_MAX) : 10;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [LW-1:0] VF_LAST  = LW'(VFRONT_LINES - 1);

    patgen_state_t state_q, state_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [LW-1:0] l_cnt_q, l_cnt_d;
    logic [LW-1:0] line_last;
    logic [1:0]    pat_q, pat_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          vsync_d, href_d, frame_start_d, frame_done_d;
    logic [7:0]    data_d;
    logic [7:0]    x8, y8;
    logic [7:0]    noise_val;

    always_comb begin
        state_d   = state_q;
        h_cnt_d   = h_cnt_q;
        l_cnt_d   = l_cnt_q;
        line_last = '0;
        case (state_q)
            ST_VSYNC:  line_last = LW'(VSYNC_LINES - 1);
            ST_VBACK:  line_last = LW'(VBACK_LINES - 1);
            ST_ACTIVE: line_last = LW'(V_ACTIVE - 1);
            ST_VFRONT: line_last = VF_LAST;
            default:   line_last = '0;
        endcase

        if (state_q == ST_IDLE) begin
            h_cnt_d = '0;
            l_cnt_d = '0;
            if (enable) begin
                state_d = ST_VSYNC;
            end
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (l_cnt_q == line_last) begin
                l_cnt_d = '0;
                case (state_q)
                    ST_VSYNC:  state_d = ST_VBACK;
                    ST_VBACK:  state_d = ST_ACTIVE;
                    ST_ACTIVE: state_d = ST_VFRONT;
                    // enable is only looked at here, so a frame always runs to completion.
                    ST_VFRONT: state_d = enable ? ST_VSYNC : ST_IDLE;
                    default:   state_d = ST_IDLE;
                endcase
            end else begin
                l_cnt_d = l_cnt_q + LW'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    // Outputs are decoded from next-state values so each register lines up with its state.
    always_comb begin
        frame_start_d = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
        frame_done_d  = (state_d == ST_VFRONT) && (h_cnt_d == H_LAST) && (l_cnt_d == VF_LAST);
        vsync_d       = (state_d == ST_VSYNC);
        href_d        = (state_d == ST_ACTIVE) && (h_cnt_d < H_ACT);
        pat_d         = frame_start_d ? pattern_sel : pat_q;
        frame_cnt_d   = frame_done_d ? (frame_cnt_q + 16'd1) : frame_cnt_q;
        x8            = 8'(h_cnt_d);
        y8            = 8'(l_cnt_d);
        data_d        = 8'h00;
        if (href_d) begin
            case (pat_d)
                PAT_HRAMP: data_d = x8;
                PAT_VRAMP: data_d = y8;
                PAT_CHECK: data_d = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
                default:   data_d = noise_val;
            endcase
        end
    end

`ifdef CMOS_PATGEN_LFSR_EN
    cmos_patgen_lfsr8 u_lfsr (
        .clk_i   (cmos_pclk),
        .rst_ni  (rst_n),
        .en_i    (href_d),
        .load_i  (frame_start_d),
        .state_o (noise_val)
    );
`else
    assign noise_val = LFSR_OFF_VAL;
`endif

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            h_cnt_q     <= '0;
            l_cnt_q     <= '0;
            pat_q       <= PAT_HRAMP;
            frame_cnt_q <= '0;
            cmos_vsync  <= 1'b0;
            cmos_href   <= 1'b0;
            cmos_data   <= 8'h00;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            l_cnt_q     <= l_cnt_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            cmos_vsync  <= vsync_d;
            cmos_href   <= href_d;
            cmos_data   <= data_d;
            frame_start <= frame_start_d;
            frame_done  <= frame_done_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign dbg_state = state_q;

endmodule
